// File: rtl/sr_pulse_sequencer.sv
// Drives the active-low S/R inputs of a master-slave SR flip-flop from one-cycle
// set/clear requests, confirms the result on q_fb and enforces a guard gap.
module sr_pulse_sequencer #(
    parameter int PULSE_CYC = 2,
    parameter int TMO_CYC   = 4,
    parameter int GAP_CYC   = 1
) (
    input  logic C,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
    input  logic q_fb,
    output logic S,
    output logic R,
    output logic busy,
    output logic done,
    output logic err,
    output logic conflict
);

    localparam int MAX_PT = (PULSE_CYC > TMO_CYC) ? PULSE_CYC : TMO_CYC;
    localparam int MAX_C  = (MAX_PT > GAP_CYC) ? MAX_PT : GAP_CYC;
    localparam int CW     = $clog2(MAX_C) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_CHECK = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          tgt, tgt_d;
    logic          s_d, r_d, done_d, err_d, conflict_d;

    // State register; S and R come straight from flops so they cannot glitch.
    always_ff @(posedge C or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            tgt      <= 1'b0;
            S        <= 1'b1;
            R        <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            conflict <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            tgt      <= tgt_d;
            S        <= s_d;
            R        <= r_d;
            done     <= done_d;
            err      <= err_d;
            conflict <= conflict_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:  if (set_req ^ clr_req) state_d = ST_PULSE;
            ST_PULSE: if (cnt == CW'(PULSE_CYC - 1)) state_d = ST_CHECK;
            ST_CHECK: if ((q_fb == tgt) || (cnt == CW'(TMO_CYC - 1))) state_d = ST_GAP;
            ST_GAP:   if (cnt == CW'(GAP_CYC - 1)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; only one of S/R can ever be driven low.
    always_comb begin
        s_d        = 1'b1;
        r_d        = 1'b1;
        done_d     = 1'b0;
        err_d      = err;
        conflict_d = 1'b0;
        tgt_d      = tgt;
        cnt_d      = (state_d != state || state == ST_IDLE) ? '0 : cnt + CW'(1);
        case (state)
            ST_IDLE: begin
                if (set_req && !clr_req) begin
                    tgt_d = 1'b1;
                    s_d   = 1'b0;
                    err_d = 1'b0;
                end else if (clr_req && !set_req) begin
                    tgt_d = 1'b0;
                    r_d   = 1'b0;
                    err_d = 1'b0;
                end else if (set_req && clr_req) begin
                    conflict_d = 1'b1;
                end
            end
            ST_PULSE: begin
                if (state_d == ST_PULSE) begin
                    s_d = ~tgt;
                    r_d = tgt;
                end
            end
            ST_CHECK: begin
                if (q_fb == tgt)                      done_d = 1'b1;
                else if (cnt == CW'(TMO_CYC - 1))     err_d  = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sr_pulse_sequencer.sv
// Bench for sr_pulse_sequencer: behavioural SR flip-flop on the outputs, event
// scoreboard for done/err/conflict timing, per-cycle checks of S/R/busy/err.
module tb_sr_pulse_sequencer;

    localparam int P = 2;
    localparam int T = 4;
    localparam int G = 1;
    localparam logic [1:0] EV_DONE = 2'd1;
    localparam logic [1:0] EV_ERR  = 2'd2;
    localparam logic [1:0] EV_CONF = 2'd3;

    logic C = 1'b0;
    logic rst_n = 1'b0;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;
    logic q_fb;
    logic S, R, busy, done, err, conflict;

    logic        ff_q = 1'b0;
    logic        tie0 = 1'b0;
    logic [13:0] cyc = '0;
    logic        err_seen = 1'b0;
    logic [15:0] exp_q[$];
    int          total = 0;
    int          bad = 0;

    sr_pulse_sequencer #(.PULSE_CYC(P), .TMO_CYC(T), .GAP_CYC(G)) dut (
        .C(C), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req), .q_fb(q_fb),
        .S(S), .R(R), .busy(busy), .done(done), .err(err), .conflict(conflict)
    );

    // clock / reset-independent plumbing
    always #5 C = ~C;
    always @(posedge C) cyc <= cyc + 14'd1;
    always @(posedge C) begin
        if (!S)      ff_q <= 1'b1;
        else if (!R) ff_q <= 1'b0;
    end
    assign q_fb = tie0 ? 1'b0 : ff_q;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic sb_pop(input logic [1:0] code);
        if (exp_q.size() == 0) check("sb_unexpected", {code, cyc}, 16'h0);
        else                   check("sb_event", {code, cyc}, exp_q.pop_front());
    endtask

    // monitor: invariant plus event scoreboard
    always @(negedge C) begin
        check("s_r_not_both_low", {15'd0, S | R}, 16'd1);
        if (done)            sb_pop(EV_DONE);
        if (conflict)        sb_pop(EV_CONF);
        if (err && !err_seen) sb_pop(EV_ERR);
        err_seen = err;
    end

    // One request pulse, then 8 cycles of per-cycle checks relative to accept edge k.
    task automatic op(input bit s, input bit c, input bit match, input bit err_prior);
        logic [13:0] m;
        bit ex_s, ex_r, ex_b, ex_e;
        @(negedge C);
        m = cyc;
        set_req = s;
        clr_req = c;
        if (s && c)  exp_q.push_back({EV_CONF, m + 14'd1});
        else if (match) exp_q.push_back({EV_DONE, m + 14'd1 + 14'(P + 1)});
        else begin
            exp_q.push_back({EV_ERR, m + 14'd1 + 14'(P + T)});
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge C);
            set_req = 1'b0;
            clr_req = 1'b0;
            ex_s = !(s && !c && i < P);
            ex_r = !(c && !s && i < P);
            if (s && c) begin
                ex_b = 1'b0;
                ex_e = err_prior;
            end else begin
                ex_b = match ? (i < P + 1 + G) : (i < P + T + G);
                ex_e = match ? 1'b0 : (i >= P + T - 1 + 1);
            end
            check("S", {15'd0, S}, {15'd0, ex_s});
            check("R", {15'd0, R}, {15'd0, ex_r});
            check("busy", {15'd0, busy}, {15'd0, ex_b});
            check("err", {15'd0, err}, {15'd0, ex_e});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] m;
        bit ex_s;
        // reset state
        repeat (2) @(negedge C);
        check("rst_S", {15'd0, S}, 16'd1);
        check("rst_R", {15'd0, R}, 16'd1);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_done_err_conf", {13'd0, done, err, conflict}, 16'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge C);

        // set from Q=0, then clear from Q=1
        op(1'b1, 1'b0, 1'b1, 1'b0);
        check("q_after_set", {15'd0, ff_q}, 16'd1);
        op(1'b0, 1'b1, 1'b1, 1'b0);
        check("q_after_clr", {15'd0, ff_q}, 16'd0);
        // both requests: conflict only, Q unchanged
        op(1'b1, 1'b1, 1'b0, 1'b0);
        check("q_after_conf", {15'd0, ff_q}, 16'd0);
        // accept still pulses when Q already equals target
        op(1'b0, 1'b1, 1'b1, 1'b0);
        // timeout with q_fb stuck low, then a clear accept drops err
        tie0 = 1'b1;
        op(1'b1, 1'b0, 1'b0, 1'b0);
        check("err_sticky", {15'd0, err}, 16'd1);
        op(1'b1, 1'b1, 1'b0, 1'b1);
        op(1'b0, 1'b1, 1'b1, 1'b1);
        tie0 = 1'b0;

        // level-held set_req for 10 edges: two accepts at k and k+5
        @(negedge C);
        m = cyc;
        set_req = 1'b1;
        exp_q.push_back({EV_DONE, m + 14'd4});
        exp_q.push_back({EV_DONE, m + 14'd9});
        for (int i = 0; i < 14; i++) begin
            @(negedge C);
            if (i == 9) set_req = 1'b0;
            ex_s = !(i == 0 || i == 1 || i == 5 || i == 6);
            check("held_S", {15'd0, S}, {15'd0, ex_s});
            check("held_R", {15'd0, R}, 16'd1);
        end

        // async reset in the middle of a pulse
        @(negedge C);
        set_req = 1'b1;
        @(negedge C);
        set_req = 1'b0;
        check("mid_pulse_S", {15'd0, S}, 16'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_S", {15'd0, S}, 16'd1);
        check("async_R", {15'd0, R}, 16'd1);
        check("async_busy", {15'd0, busy}, 16'd0);
        check("async_err", {15'd0, err}, 16'd0);
        @(negedge C);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge C);
            check("post_rst_busy", {15'd0, busy}, 16'd0);
            check("post_rst_S", {15'd0, S}, 16'd1);
        end

        check("sb_left", 16'(exp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
